// File: rtl/softmax_pkg.sv
// softmax_pkg: shared constants, payload type and FSM encoding for the
// softmax request scheduler.
//   NCLS        - number of classes (logits / probabilities per request)
//   SM_LAT      - default softmax pipeline latency in cycles
//   CLS_W       - width of a class index
//   CLS_TIMEOUT - class index reported on a timed-out response
//   logits_t    - one request/response payload: NCLS IEEE-754 singles
//   state_e     - scheduler FSM states
package softmax_pkg;

    localparam int unsigned NCLS   = 10;
    localparam int unsigned SM_LAT = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned CLS_W  = 4;

    localparam logic [CLS_W-1:0] CLS_TIMEOUT = CLS_W'(15);

    typedef logic [NCLS-1:0][DW-1:0] logits_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ARGMAX,
        S_RESP
    } state_e;

endpackage

// File: rtl/softmax_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered search pointer.
//   clk, rst  - clock, asynchronous active-high reset (pointer -> 0)
//   req       - per-requester request vector
//   advance   - grant was accepted; move pointer past the winner
//   grant     - one-hot winner, zero when no request is pending
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_c;
    logic          found_c;

    function automatic logic [IW-1:0] wrap(input int unsigned v);
        return IW'(v % NREQ);
    endfunction

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        grant   = '0;
        win_c   = ptr_q;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_c && req[wrap(32'(ptr_q) + i)]) begin
                found_c = 1'b1;
                win_c   = wrap(32'(ptr_q) + i);
            end
        end
        if (found_c) begin
            grant[win_c] = 1'b1;
        end
    end

    // Pointer holds the first index to search next time.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found_c) begin
            ptr_d = wrap(32'(win_c) + 32'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/softmax_sched.sv
// softmax_sched: shares one softmax datapath among NREQ requesters.
// One transaction in flight: grant, issue logits, wait for probabilities
// (with timeout), sequential argmax over the classes, then hold a response.
//   clk, resetn         - clock, asynchronous active-high reset
//   req_valid/ready     - per-requester handshake; req_data carries logits
//   sm_valid_in, d_in   - issue pulse and logits to the softmax unit
//   sm_valid_out, pct   - result strobe and probabilities from softmax
//   rsp_*               - response (id, probabilities, argmax class, err)
//   err_timeout/stray   - sticky error flags, cleared by err_clr
module softmax_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SM_LAT = softmax_pkg::SM_LAT,
    parameter int unsigned TMO    = SM_LAT + 3
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic [NREQ-1:0]                           req_valid,
    output logic [NREQ-1:0]                           req_ready,
    input  softmax_pkg::logits_t [NREQ-1:0]           req_data,
    output logic                                      sm_valid_in,
    output softmax_pkg::logits_t                      sm_d_in,
    input  logic                                      sm_valid_out,
    input  softmax_pkg::logits_t                      sm_percent,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output softmax_pkg::logits_t                      rsp_percent,
    output logic [softmax_pkg::CLS_W-1:0]             rsp_class,
    output logic                                      rsp_err,
    output logic                                      err_timeout,
    output logic                                      err_stray,
    input  logic                                      err_clr
);

    import softmax_pkg::*;

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WCW = $clog2(TMO + 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     id_q, id_d;
    logits_t           data_q, data_d;
    logits_t           pct_q, pct_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [CLS_W-1:0]  acnt_q, acnt_d;
    logic [DW-2:0]     best_val_q, best_val_d;
    logic [CLS_W-1:0]  best_idx_q, best_idx_d;
    logic [CLS_W-1:0]  cls_q, cls_d;
    logic              sm_valid_q, sm_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              err_to_q, err_to_d;
    logic              err_stray_q, err_stray_d;

    logic [NREQ-1:0]   grant_c;
    logic [IW-1:0]     gidx_c;
    logic              hs_c;
    logic              tmo_evt_c;
    logic              stray_evt_c;
    logic [DW-2:0]     cand_c;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (resetn),
        .req     (req_valid),
        .advance (hs_c),
        .grant   (grant_c)
    );

    // Grants are only offered while idle and out of reset.
    assign req_ready = (state_q == S_IDLE && !resetn) ? grant_c : '0;
    assign hs_c      = |(req_valid & req_ready);

    always_comb begin
        gidx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gidx_c = IW'(i);
            end
        end
    end

    // Sign bit ignored: probabilities compared by magnitude bits only.
    assign cand_c = pct_q[acnt_q][DW-2:0];

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        data_d      = data_q;
        pct_d       = pct_q;
        wcnt_d      = wcnt_q;
        acnt_d      = acnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        cls_d       = cls_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        sm_valid_d  = 1'b0;
        tmo_evt_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_c) begin
                    data_d     = req_data[gidx_c];
                    id_d       = gidx_c;
                    sm_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sm_valid_out) begin
                    pct_d   = sm_percent;
                    acnt_d  = '0;
                    state_d = S_ARGMAX;
                end else if (wcnt_q == WCW'(TMO - 1)) begin
                    pct_d       = '0;
                    cls_d       = CLS_TIMEOUT;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    tmo_evt_c   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_ARGMAX: begin
                // Strictly greater keeps the lowest index on ties.
                if (acnt_q == '0 || cand_c > best_val_q) begin
                    best_val_d = cand_c;
                    best_idx_d = acnt_q;
                end
                if (acnt_q == CLS_W'(NCLS - 1)) begin
                    cls_d       = best_idx_d;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    acnt_d = acnt_q + CLS_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky flags: a same-cycle error event beats a clear.
    always_comb begin
        stray_evt_c = sm_valid_out && (state_q != S_WAIT);
        err_to_d    = tmo_evt_c   ? 1'b1 : (err_clr ? 1'b0 : err_to_q);
        err_stray_d = stray_evt_c ? 1'b1 : (err_clr ? 1'b0 : err_stray_q);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            data_q      <= '0;
            pct_q       <= '0;
            wcnt_q      <= '0;
            acnt_q      <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            cls_q       <= '0;
            sm_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            data_q      <= data_d;
            pct_q       <= pct_d;
            wcnt_q      <= wcnt_d;
            acnt_q      <= acnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            cls_q       <= cls_d;
            sm_valid_q  <= sm_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            err_to_q    <= err_to_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign sm_valid_in = sm_valid_q;
    assign sm_d_in     = data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_percent = pct_q;
    assign rsp_class   = cls_q;
    assign rsp_err     = rsp_err_q;
    assign err_timeout = err_to_q;
    assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_softmax_sched.sv
// tb_softmax_sched: table-driven and randomized bench for softmax_sched with
// a behavioural softmax stand-in and a reference model of grant order,
// response latency and argmax.
module tb_softmax_sched;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned SM_LAT = 4;
    localparam int unsigned TMO    = SM_LAT + 3;
    localparam int unsigned NCLS   = 10;

    typedef softmax_pkg::logits_t vec_t;

    typedef struct {
        logic [NREQ-1:0] rv;
        vec_t            pct;
        logic [3:0]      cls;
    } tcase_t;

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    vec_t [NREQ-1:0]       req_data;
    logic                  sm_valid_in;
    vec_t                  sm_d_in;
    logic                  sm_valid_out;
    vec_t                  sm_percent;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    vec_t                  rsp_percent;
    logic [3:0]            rsp_class;
    logic                  rsp_err;
    logic                  err_timeout;
    logic                  err_stray;
    logic                  err_clr;

    logic                  mdl_vo;
    logic                  man_vo;
    bit                    sm_en;
    vec_t                  sm_resp;

    int                    n_tests;
    int                    n_fail;
    int                    rr_next;
    tcase_t                tbl [4];
    logic [31:0]           fl [NCLS];

    assign sm_valid_out = mdl_vo | man_vo;

    softmax_sched #(.NREQ(NREQ), .SM_LAT(SM_LAT), .TMO(TMO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .sm_valid_in  (sm_valid_in),
        .sm_d_in      (sm_d_in),
        .sm_valid_out (sm_valid_out),
        .sm_percent   (sm_percent),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_percent  (rsp_percent),
        .rsp_class    (rsp_class),
        .rsp_err      (rsp_err),
        .err_timeout  (err_timeout),
        .err_stray    (err_stray),
        .err_clr      (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Softmax stand-in: result strobe SM_LAT cycles after the issue cycle.
    initial begin
        mdl_vo     = 1'b0;
        sm_percent = '0;
        forever begin
            @(negedge clk);
            if (sm_valid_in === 1'b1 && sm_en) begin
                repeat (SM_LAT) @(posedge clk);
                #1;
                mdl_vo     = 1'b1;
                sm_percent = sm_resp;
                @(posedge clk);
                #1;
                mdl_vo = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round-robin reference: first asserted requester at or after rr_next.
    function automatic int exp_winner(input logic [NREQ-1:0] rv);
        int j;
        for (int i = 0; i < NREQ; i++) begin
            j = (rr_next + i) % NREQ;
            if (rv[j]) return j;
        end
        return 0;
    endfunction

    // Argmax reference: largest magnitude (sign ignored), first occurrence.
    function automatic logic [3:0] exp_argmax(input vec_t p);
        int best;
        best = 0;
        for (int i = 1; i < NCLS; i++) begin
            if (p[i][30:0] > p[best][30:0]) best = i;
        end
        return 4'(best);
    endfunction

    function automatic vec_t rand_pct();
        vec_t        r;
        logic [31:0] pool [4];
        logic [31:0] v;
        pool = '{32'h3E800000, 32'h3F000000, 32'h3D000000, 32'h3F400000};
        for (int c = 0; c < NCLS; c++) begin
            v    = pool[$urandom_range(0, 3)];
            v[31] = 1'($urandom_range(0, 1));
            r[c] = v;
        end
        return r;
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {req_ready, sm_valid_in, rsp_valid, rsp_id, rsp_class,
                           rsp_err, err_timeout, err_stray}, '0);
        chk({nm, "_smd"}, sm_d_in, '0);
        chk({nm, "_pct"}, rsp_percent, '0);
    endtask

    // One full transaction; called and returns at a falling edge.
    task automatic run_txn(input logic [NREQ-1:0] rv, input bit keep, input bit tmo,
                           input vec_t pct, input logic [3:0] ecls, input int hold);
        int         w, id, lat, n_issue, busy, unstable;
        vec_t       dat, s_pct;
        logic [1:0] s_id;
        logic [3:0] s_cls;
        logic       s_err;
        sm_resp   = pct;
        sm_en     = !tmo;
        req_valid = rv;
        #1;
        w = 0;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        id = exp_winner(rv);
        chk("grant", req_ready, 4'b0001 << id);
        dat = req_data[id];
        @(posedge clk);
        rr_next = (id + 1) % NREQ;
        #1;
        if (!keep) req_valid = '0;
        n_issue = 0;
        busy    = 0;
        lat     = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (sm_valid_in) begin
                n_issue++;
                chk("sm_d_in", sm_d_in, dat);
            end
            if (req_ready != '0) busy++;
            if (rsp_valid) lat = k;
        end
        chk("latency", lat, tmo ? (2 + TMO) : (SM_LAT + 2 + NCLS));
        chk("issue_cnt", n_issue, 1);
        chk("busy_ready", busy, 0);
        chk("rsp_id", rsp_id, id);
        chk("rsp_class", rsp_class, tmo ? 4'd15 : ecls);
        chk("rsp_err", rsp_err, tmo);
        chk("rsp_pct", rsp_percent, tmo ? '0 : pct);
        chk("sm_d_hold", sm_d_in, dat);
        if (tmo) chk("err_timeout", err_timeout, 1);
        if (hold > 0) begin
            s_id = rsp_id; s_cls = rsp_class; s_err = rsp_err; s_pct = rsp_percent;
            unstable = 0;
            repeat (hold) begin
                @(negedge clk);
                if (!rsp_valid || req_ready != '0 || rsp_id != s_id || rsp_class != s_cls ||
                    rsp_err != s_err || rsp_percent != s_pct) unstable++;
            end
            chk("hold_stable", unstable, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        if (req_valid != '0) chk("idle_ready", req_ready, 4'b0001 << exp_winner(req_valid));
    endtask

    initial begin
        int nrsp;
        vec_t p;
        n_tests   = 0;
        n_fail    = 0;
        rr_next   = 0;
        resetn    = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        err_clr   = 1'b0;
        man_vo    = 1'b0;
        sm_en     = 1'b1;
        sm_resp   = '0;
        fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        for (int i = 0; i < NREQ; i++)
            for (int c = 0; c < NCLS; c++) req_data[i][c] = $urandom();

        // Logits 1.0..10.0 as a monotonic stand-in for their softmax.
        tbl[0].rv = 4'b0100; tbl[0].cls = 4'd9;
        tbl[1].rv = 4'b1010; tbl[1].cls = 4'd3;
        tbl[2].rv = 4'b0001; tbl[2].cls = 4'd5;
        tbl[3].rv = 4'b1001; tbl[3].cls = 4'd0;
        for (int c = 0; c < NCLS; c++) begin
            tbl[0].pct[c] = fl[c];
            tbl[1].pct[c] = (c == 3 || c == 7) ? 32'h3E800000 : 32'h3D000000;
            tbl[2].pct[c] = (c == 5) ? 32'hBF400000 : ((c == 2) ? 32'h3F000000 : 32'h3C000000);
            tbl[3].pct[c] = 32'h3DCCCCCD;
        end

        repeat (2) @(negedge clk);
        #1;
        chk_zero("in_reset");
        resetn = 1'b0;

        // All requesters valid continuously: 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            p = rand_pct();
            run_txn(4'b1111, 1'b1, 1'b0, p, exp_argmax(p), 0);
        end
        req_valid = '0;

        for (int t = 0; t < 4; t++) begin
            if (t == 0) req_data[2] = tbl[0].pct;
            run_txn(tbl[t].rv, 1'b0, 1'b0, tbl[t].pct, tbl[t].cls, 0);
        end

        // Long backpressure with requests pending.
        p = rand_pct();
        run_txn(4'b1111, 1'b1, 1'b0, p, exp_argmax(p), 20);
        req_valid = '0;

        // Softmax never answers.
        run_txn(4'b0010, 1'b0, 1'b1, '0, 4'd15, 0);
        sm_en = 1'b1;

        // Stray strobe in IDLE together with a clear: stray wins, timeout clears.
        man_vo  = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        man_vo  = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        chk("stray_over_clr", err_stray, 1);
        chk("tmo_clr", err_timeout, 0);
        chk("stray_no_rsp", rsp_valid, 0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("stray_clr", err_stray, 0);

        // Reset during WAIT, then the late result strobe.
        sm_resp   = rand_pct();
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        resetn  = 1'b0;
        rr_next = 0;
        #1;
        chk_zero("post_rst");
        nrsp = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("abandon_no_rsp", nrsp, 0);
        chk("late_stray", err_stray, 1);
        chk("late_no_tmo", err_timeout, 0);
        p = rand_pct();
        run_txn(4'b1111, 1'b0, 1'b0, p, exp_argmax(p), 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NREQ; i++)
                for (int c = 0; c < NCLS; c++) req_data[i][c] = $urandom();
            p = rand_pct();
            run_txn(4'($urandom_range(1, 15)), 1'b0, 1'b0, p, exp_argmax(p),
                    int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
